// File: rtl/mcast_split_engine.sv
// Sequential multicast splitter for one mesh-router input port.
// Accepts one head descriptor (unicast destination or multicast bitmask), partitions
// the destination set by output port using XY or YX dimension-order routing, and
// presents one branch per cycle to the crossbar allocator (valid/ready).
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   in_valid/in_ready             head descriptor handshake (ready only when idle)
//   in_um_type/in_uni_dst/in_mult_dst  descriptor: 0=unicast, 1=multicast
//   out_valid/out_ready           branch handshake
//   out_port/out_doc/out_last     branch port, destination subset, final-branch flag
//   out_um_type/out_uni_dst       latched descriptor fields
//   drop_cnt                      saturating count of descriptors with no destination
module mcast_split_engine #(
  parameter int ROWS    = 4,
  parameter int COLS    = 4,
  parameter int MY_XPOS = 0,
  parameter int MY_YPOS = 0,
  parameter int ROUTING = 0,
  localparam int N      = ROWS * COLS,
  localparam int NW     = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_um_type,
  input  logic [NW-1:0] in_uni_dst,
  input  logic [N-1:0]  in_mult_dst,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [2:0]    out_port,
  output logic [N-1:0]  out_doc,
  output logic          out_um_type,
  output logic [NW-1:0] out_uni_dst,
  output logic          out_last,
  output logic [7:0]    drop_cnt
);

  typedef enum logic {IDLE, SPLIT} state_t;

  state_t          state, state_nxt;
  logic [N-1:0]    remaining;
  logic            um_type_q;
  logic [NW-1:0]   uni_dst_q;
  logic [7:0]      drop_q;

  logic [N-1:0]    uni_onehot;
  logic [N-1:0]    work;
  logic            accept;
  logic            take;
  logic [2:0]      sel_port;
  logic [N-1:0]    subset;
  logic            found;
  logic            branch_last;

  // Output port of node d under the configured dimension order.
  function automatic logic [2:0] port_of(input int d);
    int dx;
    int dy;
    dx = d / ROWS;
    dy = d % ROWS;
    port_of = 3'd0;
    if (ROUTING == 0) begin
      if (dx > MY_XPOS)      port_of = 3'd1;
      else if (dx < MY_XPOS) port_of = 3'd2;
      else if (dy > MY_YPOS) port_of = 3'd3;
      else if (dy < MY_YPOS) port_of = 3'd4;
    end else begin
      if (dy > MY_YPOS)      port_of = 3'd3;
      else if (dy < MY_YPOS) port_of = 3'd4;
      else if (dx > MY_XPOS) port_of = 3'd1;
      else if (dx < MY_XPOS) port_of = 3'd2;
    end
  endfunction

  // Constant mask of all nodes routed through port p.
  function automatic logic [N-1:0] port_mask(input int p);
    port_mask = '0;
    for (int d = 0; d < N; d++) begin
      port_mask[d] = (int'(port_of(d)) == p);
    end
  endfunction

  // An out-of-range unicast destination shifts the bit out entirely, so it
  // shows up as an empty work set and is dropped like an empty multicast.
  assign uni_onehot = {{(N-1){1'b0}}, 1'b1} << in_uni_dst;
  assign work       = in_um_type ? in_mult_dst : uni_onehot;
  assign accept     = in_valid && in_ready;
  assign take       = accept && (work != '0);

  // Lowest-numbered port that still has destinations; empty ports never surface.
  always_comb begin
    sel_port = 3'd0;
    subset   = '0;
    found    = 1'b0;
    for (int p = 0; p < 5; p++) begin
      if (!found && ((remaining & port_mask(p)) != '0)) begin
        found    = 1'b1;
        sel_port = 3'(p);
        subset   = remaining & port_mask(p);
      end
    end
  end

  assign branch_last = ((remaining & ~subset) == '0);

  assign in_ready    = (state == IDLE);
  assign out_valid   = (state == SPLIT);
  assign out_port    = sel_port;
  assign out_doc     = um_type_q ? subset : '0;
  assign out_last    = (state == SPLIT) && branch_last;
  assign out_um_type = um_type_q;
  assign out_uni_dst = uni_dst_q;
  assign drop_cnt    = drop_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (take) state_nxt = SPLIT;
      SPLIT:   if (out_ready && branch_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      remaining <= '0;
      um_type_q <= 1'b0;
      uni_dst_q <= '0;
      drop_q    <= 8'd0;
    end else if (take) begin
      remaining <= work;
      um_type_q <= in_um_type;
      uni_dst_q <= in_uni_dst;
    end else if (accept) begin
      if (drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
    end else if (out_valid && out_ready) begin
      remaining <= remaining & ~subset;
    end
  end

endmodule

// File: tb/tb_mcast_split_engine.sv
module tb_mcast_split_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_um_type;
  logic [3:0]  in_uni_dst;
  logic [15:0] in_mult_dst;
  logic        out_ready;

  logic        rdy0, v0, last0, um0;
  logic [2:0]  port0;
  logic [15:0] doc0;
  logic [3:0]  uni0;
  logic [7:0]  drop0;
  logic        rdy1, v1, last1, um1;
  logic [2:0]  port1;
  logic [15:0] doc1;
  logic [3:0]  uni1;
  logic [7:0]  drop1;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  mcast_split_engine #(.ROWS(4), .COLS(4), .MY_XPOS(1), .MY_YPOS(1), .ROUTING(0)) dut_xy (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .in_um_type(in_um_type),
    .in_uni_dst(in_uni_dst), .in_mult_dst(in_mult_dst), .out_valid(v0), .out_ready(out_ready),
    .out_port(port0), .out_doc(doc0), .out_um_type(um0), .out_uni_dst(uni0),
    .out_last(last0), .drop_cnt(drop0));

  mcast_split_engine #(.ROWS(4), .COLS(4), .MY_XPOS(1), .MY_YPOS(1), .ROUTING(1)) dut_yx (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .in_um_type(in_um_type),
    .in_uni_dst(in_uni_dst), .in_mult_dst(in_mult_dst), .out_valid(v1), .out_ready(out_ready),
    .out_port(port1), .out_doc(doc1), .out_um_type(um1), .out_uni_dst(uni1),
    .out_last(last1), .drop_cnt(drop1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    else passes++;
  endtask

  // ---------------- behavioural model: list of pending branches per routing ----------
  typedef struct {
    int port;
    int doc;
    bit last;
    int um;
    int uni;
  } br_t;

  br_t q0[$];
  br_t q1[$];
  int  mdrop[2];

  // Node 5 is (x=1, y=1); node d sits at x=d/4, y=d%4.
  function automatic int mport(input int r, input int d);
    int x = d / 4;
    int y = d % 4;
    if (r == 0) begin
      if (x != 1) return (x > 1) ? 1 : 2;
      if (y != 1) return (y > 1) ? 3 : 4;
    end else begin
      if (y != 1) return (y > 1) ? 3 : 4;
      if (x != 1) return (x > 1) ? 1 : 2;
    end
    return 0;
  endfunction

  function automatic void model_step(input int r);
    br_t tmp[$];
    br_t b;
    bit [15:0] w;
    int busy = (r == 0) ? q0.size() : q1.size();
    if (busy != 0) begin
      if (out_ready) begin
        if (r == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
      end
    end else if (in_valid) begin
      w = in_um_type ? in_mult_dst : (16'd1 << in_uni_dst);
      for (int p = 0; p < 5; p++) begin
        b.doc = 0;
        for (int d = 0; d < 16; d++)
          if (w[d] && mport(r, d) == p) b.doc = b.doc | (1 << d);
        if (b.doc != 0) begin
          b.port = p;
          b.last = 1'b0;
          b.um   = int'(in_um_type);
          b.uni  = int'(in_uni_dst);
          tmp.push_back(b);
        end
      end
      if (tmp.size() == 0) begin
        if (mdrop[r] < 255) mdrop[r] = mdrop[r] + 1;
      end else begin
        tmp[tmp.size()-1].last = 1'b1;
        foreach (tmp[i]) begin
          if (r == 0) q0.push_back(tmp[i]);
          else        q1.push_back(tmp[i]);
        end
      end
    end
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q0.delete();
      q1.delete();
      mdrop[0] = 0;
      mdrop[1] = 0;
    end else begin
      model_step(0);
      model_step(1);
    end
  end

  task automatic cmp_inst(input int r, input logic v, input logic rdy, input logic [2:0] port,
                          input logic [15:0] doc, input logic last, input logic um,
                          input logic [3:0] uni, input logic [7:0] drop);
    br_t e;
    bit  has = (r == 0) ? (q0.size() != 0) : (q1.size() != 0);
    chk($sformatf("r%0d_out_valid", r), v, has);
    chk($sformatf("r%0d_in_ready", r), rdy, !has);
    chk($sformatf("r%0d_drop_cnt", r), drop, mdrop[r]);
    if (has) begin
      e = (r == 0) ? q0[0] : q1[0];
      chk($sformatf("r%0d_out_port", r), port, e.port);
      chk($sformatf("r%0d_out_doc", r), doc, (e.um != 0) ? e.doc : 0);
      chk($sformatf("r%0d_out_last", r), last, e.last);
      chk($sformatf("r%0d_out_um_type", r), um, e.um);
      chk($sformatf("r%0d_out_uni_dst", r), uni, e.uni);
    end
  endtask

  always @(negedge clk) begin
    cmp_inst(0, v0, rdy0, port0, doc0, last0, um0, uni0, drop0);
    cmp_inst(1, v1, rdy1, port1, doc1, last1, um1, uni1, drop1);
  end

  // ---------------- directed stimulus with literal expectations ----------------------
  task automatic lit(input string tag, input int r, input logic [2:0] port,
                     input logic [15:0] doc, input logic last);
    if (r == 0) begin
      chk({tag, "_xy_valid"}, v0, 1'b1);
      chk({tag, "_xy_port"}, port0, port);
      chk({tag, "_xy_doc"}, doc0, doc);
      chk({tag, "_xy_last"}, last0, last);
    end else begin
      chk({tag, "_yx_valid"}, v1, 1'b1);
      chk({tag, "_yx_port"}, port1, port);
      chk({tag, "_yx_doc"}, doc1, doc);
      chk({tag, "_yx_last"}, last1, last);
    end
  endtask

  task automatic send(input logic um, input logic [3:0] uni, input logic [15:0] mask);
    @(posedge clk); #1;
    in_valid = 1'b1; in_um_type = um; in_uni_dst = uni; in_mult_dst = mask;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_um_type = 1'b0; in_uni_dst = 4'd0;
    in_mult_dst = 16'd0; out_ready = 1'b1;
    #1;
    chk("reset_out_valid", v0, 1'b0);
    chk("reset_in_ready", rdy0, 1'b1);
    chk("reset_out_port", port0, 3'd0);
    chk("reset_out_doc", doc0, 16'd0);
    chk("reset_out_last", last0, 1'b0);
    chk("reset_drop_cnt", drop0, 8'd0);
    #12 rst = 1'b0;

    // XY and YX split of 0x2061
    send(1'b1, 4'd0, 16'h2061);
    @(negedge clk); lit("mc_b1", 0, 3'd0, 16'h0020, 1'b0); lit("mc_b1", 1, 3'd0, 16'h0020, 1'b0);
    @(negedge clk); lit("mc_b2", 0, 3'd1, 16'h2000, 1'b0); lit("mc_b2", 1, 3'd1, 16'h2000, 1'b0);
    @(negedge clk); lit("mc_b3", 0, 3'd2, 16'h0001, 1'b0); lit("mc_b3", 1, 3'd3, 16'h0040, 1'b0);
    @(negedge clk); lit("mc_b4", 0, 3'd3, 16'h0040, 1'b1); lit("mc_b4", 1, 3'd4, 16'h0001, 1'b1);
    @(negedge clk);
    chk("mc_done_in_ready", rdy0, 1'b1);
    chk("mc_done_out_valid", v0, 1'b0);

    // Unicast
    send(1'b0, 4'd15, 16'hFFFF);
    @(negedge clk); lit("uc15", 0, 3'd1, 16'h0, 1'b1); lit("uc15", 1, 3'd3, 16'h0, 1'b1);
    chk("uc15_uni_dst", uni0, 4'd15);
    @(negedge clk);
    send(1'b0, 4'd5, 16'h0);
    @(negedge clk); lit("uc5", 0, 3'd0, 16'h0, 1'b1); lit("uc5", 1, 3'd0, 16'h0, 1'b1);
    @(negedge clk);

    // Stall on branch 2, with a competing head offered during SPLIT
    send(1'b1, 4'd0, 16'h2061);
    @(negedge clk); lit("st_b1", 0, 3'd0, 16'h0020, 1'b0);
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; in_um_type = 1'b0; in_uni_dst = 4'd15;
    repeat (3) begin
      @(negedge clk);
      lit("st_hold", 0, 3'd1, 16'h2000, 1'b0);
      chk("st_in_ready", rdy0, 1'b0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1; in_valid = 1'b0;
    repeat (5) @(negedge clk);

    // Empty multicasts saturate the drop counter
    @(posedge clk); #1;
    in_valid = 1'b1; in_um_type = 1'b1; in_mult_dst = 16'h0;
    repeat (300) @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("drop_sat_xy", drop0, 8'd255);
    chk("drop_sat_yx", drop1, 8'd255);

    // Asynchronous reset in the middle of a split
    send(1'b1, 4'd0, 16'h2061);
    @(negedge clk); lit("rs_b1", 0, 3'd0, 16'h0020, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", v0, 1'b0);
    chk("arst_in_ready", rdy0, 1'b1);
    chk("arst_drop_cnt", drop0, 8'd0);
    chk("arst_yx_out_valid", v1, 1'b0);
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
